// File: rtl/if_pll_retune_ctrl.sv
// PLL reconfiguration initiator for the IF synthesizer: converts a requested IF word
// into m/n/c0 divider values, runs the strobe/busy/lock handshake and reports lock.
module if_pll_retune_ctrl #(
    parameter int unsigned N_DIV   = 10,
    parameter int unsigned M_MIN   = 128,
    parameter int unsigned M_MAX   = 1023,
    parameter int unsigned C0_MAX  = 32,
    parameter int unsigned BUSY_TO = 64,
    parameter int unsigned LOCK_TO = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] if_freq,
    input  logic       freq_strobe,
    output logic [9:0] cfg_m,
    output logic [7:0] cfg_n,
    output logic [7:0] cfg_c0,
    output logic       cfg_strobe,
    output logic       pll_reset,
    input  logic       busy,
    input  logic       pll_lock,
    output logic       locked,
    output logic       error
);

    localparam int unsigned TMAX = (LOCK_TO > BUSY_TO) ? LOCK_TO : BUSY_TO;
    localparam int          TW   = $clog2(TMAX);

    localparam logic [15:0]   M_MIN_W   = 16'(M_MIN);
    localparam logic [15:0]   M_MAX_W   = 16'(M_MAX);
    localparam logic [7:0]    C0_MAX_W  = 8'(C0_MAX);
    localparam logic [7:0]    N_DIV_W   = 8'(N_DIV);
    localparam logic [TW-1:0] BUSY_LAST = TW'(BUSY_TO - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TO - 1);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        WAIT_LOCK,
        ACTIVE,
        FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [8:0]    f_req_q, f_req_d;
    logic [7:0]    c0_q, c0_d;
    logic [8:0]    pend_q, pend_d;
    logic          pend_valid_q, pend_valid_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [9:0]    cfg_m_q, cfg_m_d;
    logic [7:0]    cfg_n_q, cfg_n_d;
    logic [7:0]    cfg_c0_q, cfg_c0_d;
    logic          cfg_strobe_q, cfg_strobe_d;
    logic          pll_reset_q, pll_reset_d;
    logic          locked_q, locked_d;
    logic          error_q, error_d;
    logic [15:0]   prod;

    // Full-width product so out-of-range m is detected without wraparound
    assign prod = 16'(f_req_q) * 16'(c0_q);

    always_comb begin
        state_d      = state_q;
        f_req_d      = f_req_q;
        c0_d         = c0_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        timer_d      = timer_q;
        cfg_m_d      = cfg_m_q;
        cfg_n_d      = cfg_n_q;
        cfg_c0_d     = cfg_c0_q;
        pll_reset_d  = 1'b0;

        case (state_q)
            IDLE, ACTIVE, FAIL: begin
                // A fresh strobe overrides anything still pending
                if (freq_strobe) begin
                    f_req_d      = if_freq;
                    pend_valid_d = 1'b0;
                    c0_d         = 8'd1;
                    state_d      = CALC;
                end else if (pend_valid_q) begin
                    f_req_d      = pend_q;
                    pend_valid_d = 1'b0;
                    c0_d         = 8'd1;
                    state_d      = CALC;
                end
            end
            CALC: begin
                if (f_req_q == 9'd0) begin
                    state_d = FAIL;
                end else if ((prod < M_MIN_W) && (c0_q < C0_MAX_W)) begin
                    c0_d = c0_q << 1;
                end else if ((prod > M_MAX_W) || (prod < M_MIN_W)) begin
                    state_d = FAIL;
                end else begin
                    cfg_m_d  = prod[9:0];
                    cfg_n_d  = N_DIV_W;
                    cfg_c0_d = c0_q;
                    state_d  = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == BUSY_LAST) begin
                    state_d = FAIL;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    timer_d = '0;
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (pll_lock) begin
                    state_d = ACTIVE;
                end else if (timer_q == LOCK_LAST) begin
                    pll_reset_d = 1'b1;
                    state_d     = FAIL;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Requests arriving mid-retune are parked; the newest one wins
        if ((state_q != IDLE) && (state_q != ACTIVE) && (state_q != FAIL) && freq_strobe) begin
            pend_d       = if_freq;
            pend_valid_d = 1'b1;
        end

        cfg_strobe_d = (state_d == START);
        error_d      = (state_d == FAIL);
        locked_d     = (state_d == ACTIVE) && pll_lock && !busy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            f_req_q      <= '0;
            c0_q         <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            timer_q      <= '0;
            cfg_m_q      <= '0;
            cfg_n_q      <= '0;
            cfg_c0_q     <= '0;
            cfg_strobe_q <= 1'b0;
            pll_reset_q  <= 1'b0;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            f_req_q      <= f_req_d;
            c0_q         <= c0_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            timer_q      <= timer_d;
            cfg_m_q      <= cfg_m_d;
            cfg_n_q      <= cfg_n_d;
            cfg_c0_q     <= cfg_c0_d;
            cfg_strobe_q <= cfg_strobe_d;
            pll_reset_q  <= pll_reset_d;
            locked_q     <= locked_d;
            error_q      <= error_d;
        end
    end

    assign cfg_m      = cfg_m_q;
    assign cfg_n      = cfg_n_q;
    assign cfg_c0     = cfg_c0_q;
    assign cfg_strobe = cfg_strobe_q;
    assign pll_reset  = pll_reset_q;
    assign locked     = locked_q;
    assign error      = error_q;

endmodule
